except_ctrl: RTL and testbench

//  MEM-stage exception arbiter feeding cp0_reg and the pipeline controller.
//  - Merges per-instruction exception flags with pending hardware interrupts.
//  - Selects one exception by fixed priority and drives the excepttype, PC,

---
 rtl/except_ctrl_if.sv | 50 +++++
 rtl/except_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_except_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/except_ctrl_if.sv
// Exception-controller bus: MEM-stage inputs, CP0 view and redirect outputs.
// master = pipeline/CP0 side driving the MEM-stage view, slave = except_ctrl.
// Signals:
//   mem_valid_i, stall_i, exc_flags_i[11:0], tlb_refill_i, pc_i, in_delayslot_i,
//   mem_addr_i, cp0_{status,cause,epc,ebase}_i, wb_cp0_{we,waddr,data}_i  -> except_ctrl
//   excepttype_o, cur_pc_o, delayslot_o, badaddr_o, mem_kill_o,
//   flush_o, new_pc_o, exc_count_o                                       <- except_ctrl
interface except_ctrl_if;
    localparam int unsigned EXC_W = 32;

    logic             mem_valid_i;
    logic             stall_i;
    logic [11:0]      exc_flags_i;
    logic             tlb_refill_i;
    logic [31:0]      pc_i;
    logic             in_delayslot_i;
    logic [31:0]      mem_addr_i;
    logic [31:0]      cp0_status_i;
    logic [31:0]      cp0_cause_i;
    logic [31:0]      cp0_epc_i;
    logic [31:0]      cp0_ebase_i;
    logic             wb_cp0_we_i;
    logic [4:0]       wb_cp0_waddr_i;
    logic [31:0]      wb_cp0_data_i;

    logic [EXC_W-1:0] excepttype_o;
    logic [31:0]      cur_pc_o;
    logic             delayslot_o;
    logic [31:0]      badaddr_o;
    logic             mem_kill_o;
    logic             flush_o;
    logic [31:0]      new_pc_o;
    logic [31:0]      exc_count_o;

    modport master (
        output mem_valid_i, stall_i, exc_flags_i, tlb_refill_i, pc_i, in_delayslot_i,
               mem_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_ebase_i,
               wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
        input  excepttype_o, cur_pc_o, delayslot_o, badaddr_o, mem_kill_o,
               flush_o, new_pc_o, exc_count_o
    );

    modport slave (
        input  mem_valid_i, stall_i, exc_flags_i, tlb_refill_i, pc_i, in_delayslot_i,
               mem_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_ebase_i,
               wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
        output excepttype_o, cur_pc_o, delayslot_o, badaddr_o, mem_kill_o,
               flush_o, new_pc_o, exc_count_o
    );
endinterface

// File: rtl/except_ctrl.sv
// MEM-stage exception arbiter. Merges instruction exception flags with pending
// interrupts, picks one by fixed priority, feeds CP0 (excepttype/PC/delay slot/
// bad address), kills the MEM instruction, and issues a registered flush with
// the redirect PC. A hold window after each flush masks re-entry.
// Ports: clk, rst (synchronous, active-high), bus (except_ctrl_if.slave).
// excepttype_o encoding: 0 = none, otherwise {26'b0, 1'b1, ExcCode[4:0]};
//   ExcCode 0 Int, 1 Mod, 2 TLBL, 3 TLBS, 4 AdEL, 5 AdES, 8 Sys, 10 RI,
//   12 Ov, 13 Tr, and 31 for ERET.
module except_ctrl #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter logic [31:0] RESET_VEC   = 32'hBFC00000
) (
    input  logic         clk,
    input  logic         rst,
    except_ctrl_if.slave bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [XLEN-1:0] EXC_NONE = 32'h00;
    localparam logic [XLEN-1:0] EXC_INT  = 32'h20;
    localparam logic [XLEN-1:0] EXC_MOD  = 32'h21;
    localparam logic [XLEN-1:0] EXC_TLBL = 32'h22;
    localparam logic [XLEN-1:0] EXC_TLBS = 32'h23;
    localparam logic [XLEN-1:0] EXC_ADEL = 32'h24;
    localparam logic [XLEN-1:0] EXC_ADES = 32'h25;
    localparam logic [XLEN-1:0] EXC_SYS  = 32'h28;
    localparam logic [XLEN-1:0] EXC_RI   = 32'h2A;
    localparam logic [XLEN-1:0] EXC_OV   = 32'h2C;
    localparam logic [XLEN-1:0] EXC_TR   = 32'h2D;
    localparam logic [XLEN-1:0] EXC_ERET = 32'h3F;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;
    localparam logic [4:0] CP0_EBASE  = 5'd15;

    localparam int unsigned F_ADEL_F = 0;
    localparam int unsigned F_TLBL_F = 1;
    localparam int unsigned F_RI     = 2;
    localparam int unsigned F_OV     = 3;
    localparam int unsigned F_TRAP   = 4;
    localparam int unsigned F_SYS    = 5;
    localparam int unsigned F_ERET   = 6;
    localparam int unsigned F_ADEL_D = 7;
    localparam int unsigned F_ADES   = 8;
    localparam int unsigned F_TLBL_D = 9;
    localparam int unsigned F_TLBS_D = 10;
    localparam int unsigned F_MOD    = 11;

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_HOLD} state_e;
    typedef enum logic [1:0] {BAD_NONE, BAD_PC, BAD_ADDR} bad_src_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              flush_q, flush_d;
    logic [XLEN-1:0]   new_pc_q, new_pc_d;
    logic [XLEN-1:0]   count_q, count_d;

    logic [XLEN-1:0]   status, cause, epc, ebase;
    logic              irq;
    logic              sel_hit, sel_tlb, sel_eret;
    logic [XLEN-1:0]   sel_code;
    bad_src_e          sel_bad;
    logic              take;
    logic [XLEN-1:0]   vec_base, vec_off, vec;
    logic              unused_bits;

    // CP0 view with the WB-stage mtc0 forwarded in
    always_comb begin
        status = bus.cp0_status_i;
        cause  = bus.cp0_cause_i;
        epc    = bus.cp0_epc_i;
        ebase  = bus.cp0_ebase_i;
        if (bus.wb_cp0_we_i) begin
            case (bus.wb_cp0_waddr_i)
                CP0_STATUS: status     = bus.wb_cp0_data_i;
                CP0_CAUSE:  cause[9:8] = bus.wb_cp0_data_i[9:8];
                CP0_EPC:    epc        = bus.wb_cp0_data_i;
                CP0_EBASE:  ebase      = bus.wb_cp0_data_i;
                default:    ;
            endcase
        end
    end

    assign irq = bus.mem_valid_i & (|(cause[15:8] & status[15:8]))
               & status[0] & ~status[1] & ~status[2];

    // Fixed-priority pick, first match wins
    always_comb begin
        sel_hit  = 1'b1;
        sel_code = EXC_NONE;
        sel_bad  = BAD_NONE;
        sel_tlb  = 1'b0;
        sel_eret = 1'b0;
        if (irq)                                  sel_code = EXC_INT;
        else if (bus.exc_flags_i[F_ADEL_F]) begin sel_code = EXC_ADEL; sel_bad = BAD_PC; end
        else if (bus.exc_flags_i[F_TLBL_F]) begin sel_code = EXC_TLBL; sel_bad = BAD_PC; sel_tlb = 1'b1; end
        else if (bus.exc_flags_i[F_RI])           sel_code = EXC_RI;
        else if (bus.exc_flags_i[F_OV])           sel_code = EXC_OV;
        else if (bus.exc_flags_i[F_TRAP])         sel_code = EXC_TR;
        else if (bus.exc_flags_i[F_SYS])          sel_code = EXC_SYS;
        else if (bus.exc_flags_i[F_ERET])   begin sel_code = EXC_ERET; sel_eret = 1'b1; end
        else if (bus.exc_flags_i[F_ADEL_D]) begin sel_code = EXC_ADEL; sel_bad = BAD_ADDR; end
        else if (bus.exc_flags_i[F_ADES])   begin sel_code = EXC_ADES; sel_bad = BAD_ADDR; end
        else if (bus.exc_flags_i[F_TLBL_D]) begin sel_code = EXC_TLBL; sel_bad = BAD_ADDR; sel_tlb = 1'b1; end
        else if (bus.exc_flags_i[F_TLBS_D]) begin sel_code = EXC_TLBS; sel_bad = BAD_ADDR; sel_tlb = 1'b1; end
        else if (bus.exc_flags_i[F_MOD])    begin sel_code = EXC_MOD;  sel_bad = BAD_ADDR; end
        else                                      sel_hit = 1'b0;
    end

    assign take = ~rst & (state_q == S_IDLE) & bus.mem_valid_i & ~bus.stall_i & sel_hit;

    // Handler vector; TLB refill outside EXL uses the 0x000 entry
    assign vec_base = status[22] ? 32'hBFC00200 : {ebase[31:12], 12'h000};
    assign vec_off  = (sel_tlb & bus.tlb_refill_i & ~status[1]) ? 32'h0 : 32'h180;
    assign vec      = sel_eret ? epc : vec_base + vec_off;

    assign bus.excepttype_o = take ? sel_code : EXC_NONE;
    assign bus.mem_kill_o   = take;
    assign bus.cur_pc_o     = bus.pc_i;
    assign bus.delayslot_o  = bus.in_delayslot_i;

    always_comb begin
        bus.badaddr_o = '0;
        if (take) begin
            case (sel_bad)
                BAD_PC:   bus.badaddr_o = bus.pc_i;
                BAD_ADDR: bus.badaddr_o = bus.mem_addr_i;
                default:  bus.badaddr_o = '0;
            endcase
        end
    end

    // Next state and registered outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        flush_d  = 1'b0;
        new_pc_d = new_pc_q;
        count_d  = count_q;
        case (state_q)
            S_IDLE: begin
                if (take) begin
                    state_d  = S_FLUSH;
                    flush_d  = 1'b1;
                    new_pc_d = vec;
                    if (!sel_eret) count_d = count_q + 32'd1;
                end
            end
            S_FLUSH: begin
                state_d = S_HOLD;
                cnt_d   = HOLD_INIT;
            end
            S_HOLD: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            flush_q  <= 1'b0;
            new_pc_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            flush_q  <= flush_d;
            new_pc_q <= new_pc_d;
            count_q  <= count_d;
        end
    end

    assign bus.flush_o     = flush_q;
    assign bus.new_pc_o    = new_pc_q;
    assign bus.exc_count_o = count_q;

    // CP0 fields this block does not look at
    assign unused_bits = ^{cause[31:16], cause[7:0], status[31:23], status[21:16],
                           status[7:3], ebase[11:0], RESET_VEC};
endmodule

// File: tb/tb_except_ctrl.sv
// Testbench for except_ctrl: directed scenarios followed by randomized
// stimulus checked against a cycle-level reference model.
module tb_except_ctrl;
    localparam int unsigned HOLD = 2;

    localparam logic [31:0] E_NONE = 32'h00, E_INT  = 32'h20, E_MOD  = 32'h21;
    localparam logic [31:0] E_TLBL = 32'h22, E_TLBS = 32'h23, E_ADEL = 32'h24;
    localparam logic [31:0] E_ADES = 32'h25, E_SYS  = 32'h28, E_RI   = 32'h2A;
    localparam logic [31:0] E_OV   = 32'h2C, E_TR   = 32'h2D, E_ERET = 32'h3F;

    // Priority order after irq is the flag bit order, lowest bit first
    localparam logic [31:0] CODE_TAB [12] = '{E_ADEL, E_TLBL, E_RI, E_OV, E_TR, E_SYS,
                                              E_ERET, E_ADEL, E_ADES, E_TLBL, E_TLBS, E_MOD};
    localparam int BAD_TAB [12] = '{1, 1, 0, 0, 0, 0, 0, 2, 2, 2, 2, 2};
    localparam bit TLB_TAB [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    localparam int B_RI = 2, B_OV = 3, B_ERET = 6, B_TLBL_D = 9;

    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   errors = 0;

    int          busy;
    logic        m_flush;
    logic [31:0] m_new_pc, m_count;

    except_ctrl_if bus();

    except_ctrl #(.HOLD_CYCLES(HOLD), .RESET_VEC(32'hBFC00000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_in();
        bus.mem_valid_i    = 1'b0;
        bus.stall_i        = 1'b0;
        bus.exc_flags_i    = '0;
        bus.tlb_refill_i   = 1'b0;
        bus.pc_i           = 32'h0;
        bus.in_delayslot_i = 1'b0;
        bus.mem_addr_i     = 32'h0;
        bus.cp0_status_i   = 32'h0;
        bus.cp0_cause_i    = 32'h0;
        bus.cp0_epc_i      = 32'h0;
        bus.cp0_ebase_i    = 32'h80000000;
        bus.wb_cp0_we_i    = 1'b0;
        bus.wb_cp0_waddr_i = 5'd0;
        bus.wb_cp0_data_i  = 32'h0;
    endtask

    // Let FLUSH and the hold window pass so the next negedge is IDLE
    task automatic settle();
        idle_in();
        repeat (3) step();
    endtask

    function automatic logic [11:0] flag(input int b);
        logic [11:0] f;
        f    = '0;
        f[b] = 1'b1;
        return f;
    endfunction

    // Reference evaluation of the current inputs from the architectural rules
    task automatic ref_eval(output bit hit, output logic [31:0] code, output logic [31:0] bad,
                            output logic [31:0] vec, output bit is_eret);
        logic [31:0] st, ca, ep, eb, base, off;
        bit irq, tlb;
        int kind;
        st = bus.cp0_status_i; ca = bus.cp0_cause_i; ep = bus.cp0_epc_i; eb = bus.cp0_ebase_i;
        if (bus.wb_cp0_we_i) begin
            if (bus.wb_cp0_waddr_i == 5'd12) st = bus.wb_cp0_data_i;
            if (bus.wb_cp0_waddr_i == 5'd13) ca[9:8] = bus.wb_cp0_data_i[9:8];
            if (bus.wb_cp0_waddr_i == 5'd14) ep = bus.wb_cp0_data_i;
            if (bus.wb_cp0_waddr_i == 5'd15) eb = bus.wb_cp0_data_i;
        end
        irq = bus.mem_valid_i && ((ca[15:8] & st[15:8]) != 8'h0) && st[0] && !st[1] && !st[2];
        hit = 0; code = E_NONE; kind = 0; tlb = 0;
        if (irq) begin
            hit = 1; code = E_INT;
        end else begin
            for (int k = 0; k < 12; k++) begin
                if (!hit && bus.exc_flags_i[k]) begin
                    hit = 1; code = CODE_TAB[k]; kind = BAD_TAB[k]; tlb = TLB_TAB[k];
                end
            end
        end
        is_eret = (code == E_ERET);
        bad  = (kind == 1) ? bus.pc_i : (kind == 2) ? bus.mem_addr_i : 32'h0;
        base = st[22] ? 32'hBFC00200 : {eb[31:12], 12'h000};
        off  = (tlb && bus.tlb_refill_i && !st[1]) ? 32'h0 : 32'h180;
        vec  = is_eret ? ep : base + off;
    endtask

    initial begin
        bit          hit, is_eret, tk;
        logic [31:0] code, bad, vec;
        logic [11:0] fl;

        // Reset forces the combinational outputs and clears the registers
        idle_in();
        rst = 1'b1;
        bus.mem_valid_i = 1'b1;
        bus.exc_flags_i = flag(B_OV);
        step(); #1;
        check("rst_etype", bus.excepttype_o, E_NONE);
        check("rst_kill", 32'(bus.mem_kill_o), 0);
        step(); rst = 1'b0; idle_in(); #1;
        check("rst_flush", 32'(bus.flush_o), 0);
        check("rst_newpc", bus.new_pc_o, 32'h0);
        check("rst_count", bus.exc_count_o, 32'h0);

        // Overflow through EBase
        bus.mem_valid_i = 1'b1; bus.pc_i = 32'h80001000; bus.exc_flags_i = flag(B_OV); #1;
        check("ov_etype", bus.excepttype_o, E_OV);
        check("ov_kill", 32'(bus.mem_kill_o), 1);
        check("ov_curpc", bus.cur_pc_o, 32'h80001000);
        check("ov_badaddr", bus.badaddr_o, 32'h0);
        step(); idle_in(); #1;
        check("ov_flush", 32'(bus.flush_o), 1);
        check("ov_newpc", bus.new_pc_o, 32'h80000180);
        check("ov_count", bus.exc_count_o, 32'd1);
        settle();

        // Interrupt beats ri
        bus.mem_valid_i = 1'b1; bus.cp0_status_i = 32'h00000401; bus.cp0_cause_i = 32'h00000400;
        bus.exc_flags_i = flag(B_RI); #1;
        check("irq_etype", bus.excepttype_o, E_INT);
        step(); idle_in(); #1;
        check("irq_count", bus.exc_count_o, 32'd2);
        settle();

        // TLB load refill, BEV=1, EXL=0 then EXL=1
        for (int e = 0; e < 2; e++) begin
            bus.mem_valid_i = 1'b1; bus.cp0_status_i = 32'h00400000 | 32'(e * 2);
            bus.exc_flags_i = flag(B_TLBL_D); bus.tlb_refill_i = 1'b1;
            bus.pc_i = 32'h80000400; bus.mem_addr_i = 32'h12345678; #1;
            check("tlb_etype", bus.excepttype_o, E_TLBL);
            check("tlb_badaddr", bus.badaddr_o, 32'h12345678);
            step(); idle_in(); #1;
            check("tlb_newpc", bus.new_pc_o, (e == 0) ? 32'hBFC00200 : 32'hBFC00380);
            settle();
        end

        // mtc0 Status clearing IE hides a pending interrupt
        bus.mem_valid_i = 1'b1; bus.cp0_status_i = 32'h00000401; bus.cp0_cause_i = 32'h00000400;
        bus.wb_cp0_we_i = 1'b1; bus.wb_cp0_waddr_i = 5'd12; bus.wb_cp0_data_i = 32'h00000400; #1;
        check("fwd_ie_etype", bus.excepttype_o, E_NONE);
        step(); idle_in(); #1;
        check("fwd_ie_flush", 32'(bus.flush_o), 0);

        // mtc0 EPC forwarded to eret; eret is not counted
        bus.mem_valid_i = 1'b1; bus.exc_flags_i = flag(B_ERET);
        bus.wb_cp0_we_i = 1'b1; bus.wb_cp0_waddr_i = 5'd14; bus.wb_cp0_data_i = 32'h80002000; #1;
        check("eret_etype", bus.excepttype_o, E_ERET);
        step(); idle_in(); #1;
        check("eret_newpc", bus.new_pc_o, 32'h80002000);
        check("eret_count", bus.exc_count_o, 32'd4);
        settle();

        // ri held asserted: masked in FLUSH and HOLD, taken back in IDLE
        bus.mem_valid_i = 1'b1; bus.exc_flags_i = flag(B_RI); #1;
        check("hold_first", bus.excepttype_o, E_RI);
        for (int k = 0; k < 1 + int'(HOLD); k++) begin
            step(); #1;
            check("hold_mask", bus.excepttype_o, E_NONE);
        end
        step(); #1;
        check("hold_retake", bus.excepttype_o, E_RI);
        step(); idle_in(); #1;
        check("hold_count", bus.exc_count_o, 32'd6);
        settle();

        // Stall delays the take
        bus.mem_valid_i = 1'b1; bus.exc_flags_i = flag(B_OV); bus.stall_i = 1'b1; #1;
        check("stall_etype", bus.excepttype_o, E_NONE);
        step(); #1;
        check("stall_flush", 32'(bus.flush_o), 0);
        bus.stall_i = 1'b0; #1;
        check("stall_release", bus.excepttype_o, E_OV);
        step(); idle_in(); #1;
        check("stall_count", bus.exc_count_o, 32'd7);
        settle();

        // Reset during FLUSH drops the flush
        bus.mem_valid_i = 1'b1; bus.exc_flags_i = flag(B_OV);
        step(); idle_in(); #1;
        check("rstf_flush1", 32'(bus.flush_o), 1);
        rst = 1'b1;
        step(); rst = 1'b0; #1;
        check("rstf_flush0", 32'(bus.flush_o), 0);
        check("rstf_count", bus.exc_count_o, 32'h0);
        bus.mem_valid_i = 1'b1; bus.exc_flags_i = flag(B_OV); #1;
        check("rstf_idle", bus.excepttype_o, E_OV);
        settle();

        // Randomized phase against the reference model
        busy = 0; m_flush = 1'b0; m_new_pc = '0; m_count = '0;
        for (int i = 0; i < 1500; i++) begin
            step();
            if (i > 0) begin
                check("r_flush", 32'(bus.flush_o), 32'(m_flush));
                check("r_count", bus.exc_count_o, m_count);
                if (m_flush) check("r_newpc", bus.new_pc_o, m_new_pc);
            end
            rst = (i == 0) || ($urandom_range(63) == 0);
            bus.mem_valid_i    = ($urandom_range(7) != 0);
            bus.stall_i        = ($urandom_range(4) == 0);
            fl = '0;
            for (int b = 0; b < 12; b++) fl[b] = ($urandom_range(9) == 0);
            bus.exc_flags_i    = fl;
            bus.tlb_refill_i   = 1'($urandom_range(1));
            bus.pc_i           = $urandom;
            bus.in_delayslot_i = 1'($urandom_range(1));
            bus.mem_addr_i     = $urandom;
            bus.cp0_status_i   = $urandom;
            bus.cp0_status_i[0] = ($urandom_range(3) != 0);
            bus.cp0_status_i[1] = ($urandom_range(3) == 0);
            bus.cp0_status_i[2] = ($urandom_range(3) == 0);
            bus.cp0_cause_i    = $urandom;
            bus.cp0_epc_i      = $urandom;
            bus.cp0_ebase_i    = $urandom;
            bus.wb_cp0_we_i    = ($urandom_range(3) == 0);
            bus.wb_cp0_waddr_i = ($urandom_range(1) == 0) ? 5'($urandom_range(12, 15))
                                                          : 5'($urandom_range(31));
            bus.wb_cp0_data_i  = $urandom;
            #1;
            ref_eval(hit, code, bad, vec, is_eret);
            tk = !rst && (busy == 0) && bus.mem_valid_i && !bus.stall_i && hit;
            check("r_etype", bus.excepttype_o, tk ? code : E_NONE);
            check("r_kill", 32'(bus.mem_kill_o), 32'(tk));
            check("r_badaddr", bus.badaddr_o, tk ? bad : 32'h0);
            check("r_curpc", bus.cur_pc_o, bus.pc_i);
            check("r_dslot", 32'(bus.delayslot_o), 32'(bus.in_delayslot_i));
            if (rst) begin
                busy = 0; m_flush = 1'b0; m_new_pc = '0; m_count = '0;
            end else begin
                m_flush = tk;
                if (tk) begin
                    m_new_pc = vec;
                    if (!is_eret) m_count = m_count + 32'd1;
                    busy = 1 + int'(HOLD);
                end else if (busy > 0) begin
                    busy--;
                end
            end
        end
        step();
        check("r_flush_end", 32'(bus.flush_o), 32'(m_flush));
        check("r_count_end", bus.exc_count_o, m_count);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
